// File: rtl/fft_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer_if
//   Avalon-MM bus between the frame sequencer (master) and the fft_avalon
//   slave. No readdatavalid: read data is valid on the cycle a read
//   completes (strobe high, waitrequest low).
//
//   address      master -> slave  32  byte address
//   write        master -> slave   1  write strobe
//   read         master -> slave   1  read strobe
//   writedata    master -> slave  32  write data
//   readdata     slave -> master  32  read data
//   waitrequest  slave -> master   1  slave stall
// ---------------------------------------------------------------------------
interface fft_frame_sequencer_if;
   logic [31:0] address;
   logic        write;
   logic        read;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address, write, read, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, write, read, writedata,
      output readdata, waitrequest
   );
endinterface

// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
//   Drives the fft_avalon slave for one audio frame at a time. It collects
//   FRAME_LEN stream samples into the FFT input window, starts the
//   transform, polls status until done, then scans the magnitude bins
//   1..FRAME_LEN/2-1 and reports the peak.
//
//   Optional feature macro: FFT_SEQ_TIMEOUT_EN
//     defined   : POLL gives up after TIMEOUT status reads, sets sticky err
//     undefined : POLL waits forever, err tied to 0
//
// Ports
//   clk         in    1   system clock
//   reset_n     in    1   asynchronous active-low reset
//   start       in    1   pulse; begins a frame when IDLE
//   s_valid     in    1   audio sample valid
//   s_data      in   16   signed audio sample
//   s_ready     out   1   sample accepted when s_valid & s_ready
//   fft         master    Avalon-MM bus (fft_frame_sequencer_if)
//   busy        out   1   high in every state except IDLE
//   frame_done  out   1   one-cycle pulse when peak outputs update
//   peak_bin    out  clog2(FRAME_LEN)  index of the largest bin
//   peak_mag    out  32   magnitude of peak_bin
//   err         out   1   poll timeout, sticky until next start
// ---------------------------------------------------------------------------
module fft_frame_sequencer #(
   parameter int unsigned FRAME_LEN   = 256,
   parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
   parameter logic [31:0] RESULT_BASE = 32'h0000_1000,
   parameter logic [31:0] CTRL_ADDR   = 32'h0000_2000,
   parameter logic [31:0] STATUS_ADDR = 32'h0000_2004
`ifdef FFT_SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT     = 4096
`endif
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         s_valid,
   input  logic [15:0]                  s_data,
   output logic                         s_ready,
   fft_frame_sequencer_if.master        fft,
   output logic                         busy,
   output logic                         frame_done,
   output logic [$clog2(FRAME_LEN)-1:0] peak_bin,
   output logic [31:0]                  peak_mag,
   output logic                         err
);

   localparam int unsigned BIN_W = $clog2(FRAME_LEN);
   localparam int unsigned K_W   = BIN_W + 1;

   // Sample count after the whole window is accepted, and the last bin read.
   localparam logic [K_W-1:0] K_FULL     = K_W'(FRAME_LEN);
   localparam logic [K_W-1:0] K_LAST_BIN = K_W'(FRAME_LEN / 2 - 1);
   localparam logic [K_W-1:0] K_ONE      = K_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_POLL,
      S_READ,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [K_W-1:0]     k_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic               write_q;
   logic               read_q;
   logic [31:0]        max_mag_q;
   logic [BIN_W-1:0]   max_bin_q;
   logic [31:0]        peak_mag_q;
   logic [BIN_W-1:0]   peak_bin_q;
   logic               frame_done_q;

   logic               wr_done;
   logic               rd_done;
   logic               accept;
   logic               timeout_hit;

   // A transfer completes on any cycle its strobe is high and the slave is not stalling.
   assign wr_done = write_q & ~fft.waitrequest;
   assign rd_done = read_q  & ~fft.waitrequest;
   assign accept  = s_valid & s_ready;

   // ---------------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state
   // NOTE: the default assignment at the top keeps this block free of latches
   // on paths that do not assign state_d.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  if (wr_done && k_q == K_FULL) state_d = S_START;
         S_START: if (wr_done) state_d = S_POLL;
         S_POLL: begin
            if (rd_done && fft.readdata[0]) state_d = S_READ;
            else if (timeout_hit)           state_d = S_IDLE;
         end
         S_READ:  if (rd_done && k_q == K_LAST_BIN) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // A new sample is taken only once the previous sample's write has gone
   // (or is going) out, so one write is outstanding at most.
   always_comb begin
      busy    = (state_q != S_IDLE);
      s_ready = (state_q == S_LOAD) && (k_q != K_FULL) &&
                (!write_q || !fft.waitrequest);
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k_q          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         max_mag_q    <= '0;
         max_bin_q    <= '0;
         peak_mag_q   <= '0;
         peak_bin_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) k_q <= '0;
            end
            S_LOAD: begin
               if (accept) begin
                  write_q <= 1'b1;
                  addr_q  <= DATA_BASE + {30'(k_q), 2'b00};
                  wdata_q <= {{16{s_data[15]}}, s_data};
                  k_q     <= k_q + K_ONE;
               end else if (wr_done) begin
                  if (k_q == K_FULL) begin
                     // Window complete: chain straight into the start command.
                     addr_q  <= CTRL_ADDR;
                     wdata_q <= 32'h1;
                  end else begin
                     write_q <= 1'b0;
                  end
               end
            end
            S_START: begin
               if (wr_done) begin
                  write_q <= 1'b0;
                  read_q  <= 1'b1;
                  addr_q  <= STATUS_ADDR;
               end
            end
            S_POLL: begin
               // read_q stays high on a not-done status, issuing the next poll.
               if (rd_done) begin
                  if (fft.readdata[0]) begin
                     k_q    <= K_ONE;
                     addr_q <= RESULT_BASE + 32'd4;
                  end else if (timeout_hit) begin
                     read_q <= 1'b0;
                  end
               end
            end
            S_READ: begin
               if (rd_done) begin
                  // Bin 1 seeds the running max; strict > keeps the lower index on ties.
                  if (k_q == K_ONE || fft.readdata > max_mag_q) begin
                     max_mag_q <= fft.readdata;
                     max_bin_q <= k_q[BIN_W-1:0];
                  end
                  if (k_q == K_LAST_BIN) begin
                     read_q <= 1'b0;
                  end else begin
                     k_q    <= k_q + K_ONE;
                     addr_q <= RESULT_BASE + {30'(k_q + K_ONE), 2'b00};
                  end
               end
            end
            S_DONE: begin
               peak_mag_q   <= max_mag_q;
               peak_bin_q   <= max_bin_q;
               frame_done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- poll timeout
`ifdef FFT_SEQ_TIMEOUT_EN
   localparam int unsigned     PC_W      = $clog2(TIMEOUT + 1);
   localparam logic [PC_W-1:0] POLL_LAST = PC_W'(TIMEOUT - 1);

   logic [PC_W-1:0] poll_cnt_q;
   logic            err_q;

   // poll_cnt_q holds the number of status reads already completed.
   assign timeout_hit = (state_q == S_POLL) && rd_done && !fft.readdata[0] &&
                        (poll_cnt_q == POLL_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         poll_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (state_q == S_IDLE && start) err_q <= 1'b0;
         else if (timeout_hit)           err_q <= 1'b1;

         if (state_q == S_START)                poll_cnt_q <= '0;
         else if (state_q == S_POLL && rd_done) poll_cnt_q <= poll_cnt_q + PC_W'(1);
      end
   end

   assign err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   assign fft.address   = addr_q;
   assign fft.write     = write_q;
   assign fft.read      = read_q;
   assign fft.writedata = wdata_q;
   assign frame_done    = frame_done_q;
   assign peak_bin      = peak_bin_q;
   assign peak_mag      = peak_mag_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sequencer
//   FRAME_LEN=8 bench. A slave model with 0-3 random waitrequest cycles
//   answers the sequencer; the stimulus side pushes the expected Avalon
//   transfer list and peak result into queues, and a negedge monitor pops
//   and compares whenever a transfer completes or frame_done pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

   localparam int          FRAME_LEN   = 8;
   localparam int          NBINS       = FRAME_LEN / 2;
   localparam int          BIN_W       = $clog2(FRAME_LEN);
   localparam logic [31:0] DATA_BASE   = 32'h0000_0000;
   localparam logic [31:0] RESULT_BASE = 32'h0000_1000;
   localparam logic [31:0] CTRL_ADDR   = 32'h0000_2000;
   localparam logic [31:0] STATUS_ADDR = 32'h0000_2004;

   typedef struct {
      bit          is_write;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   typedef struct {
      logic [31:0] bin;
      logic [31:0] mag;
   } peak_t;

   logic             clk     = 1'b0;
   logic             reset_n = 1'b0;
   logic             start   = 1'b0;
   logic             s_valid = 1'b0;
   logic [15:0]      s_data  = 16'h0;
   logic             s_ready;
   logic             busy;
   logic             frame_done;
   logic [BIN_W-1:0] peak_bin;
   logic [31:0]      peak_mag;
   logic             err;

   fft_frame_sequencer_if fft_bus ();

   fft_frame_sequencer #(
      .FRAME_LEN  (FRAME_LEN),
      .DATA_BASE  (DATA_BASE),
      .RESULT_BASE(RESULT_BASE),
      .CTRL_ADDR  (CTRL_ADDR),
      .STATUS_ADDR(STATUS_ADDR)
`ifdef FFT_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT    (4)
`endif
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .fft       (fft_bus),
      .busy      (busy),
      .frame_done(frame_done),
      .peak_bin  (peak_bin),
      .peak_mag  (peak_mag),
      .err       (err)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- scoreboard state
   int          n_checks = 0;
   int          n_fail   = 0;
   xfer_t       exp_xfer[$];
   peak_t       exp_peak[$];
   bit          status_seq[$];   // status bit0 per poll; empty => 0 forever
   logic [31:0] bin_val[NBINS];
   logic [15:0] samples[FRAME_LEN];
   int          done_cnt   = 0;
   int          status_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- slave model + monitor
   int          wait_left = -1;
   bit          prev_stall = 1'b0;
   bit          prev_fd    = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic        prev_rd, prev_wr;

   always @(negedge clk) begin
      if (!reset_n) begin
         wait_left           = -1;
         prev_stall          = 1'b0;
         prev_fd             = 1'b0;
         fft_bus.waitrequest = 1'b0;
         fft_bus.readdata    = 32'h0;
      end else begin
         // Request signals must not move while the slave stalls.
         if (prev_stall) begin
            check("hold_address",   fft_bus.address,   prev_addr);
            check("hold_read",      fft_bus.read,      prev_rd);
            check("hold_write",     fft_bus.write,     prev_wr);
            check("hold_writedata", fft_bus.writedata, prev_wdata);
         end

         if (fft_bus.read || fft_bus.write) begin
            if (wait_left < 0) wait_left = $urandom_range(0, 3);
            if (wait_left > 0) begin
               fft_bus.waitrequest = 1'b1;
               wait_left--;
            end else begin
               // Transfer completes at the coming posedge.
               fft_bus.waitrequest = 1'b0;
               wait_left           = -1;
               check("rd_wr_exclusive", fft_bus.read & fft_bus.write, 1'b0);
               if (fft_bus.read && fft_bus.address == STATUS_ADDR) begin
                  status_cnt++;
                  fft_bus.readdata = (status_seq.size() != 0) ? {31'h0, status_seq.pop_front()} : 32'h0;
               end else if (fft_bus.read && fft_bus.address >= RESULT_BASE &&
                            fft_bus.address < RESULT_BASE + 4 * NBINS) begin
                  fft_bus.readdata = bin_val[(fft_bus.address - RESULT_BASE) >> 2];
               end else begin
                  fft_bus.readdata = $urandom;
               end
               check("xfer_expected", exp_xfer.size() != 0, 1'b1);
               if (exp_xfer.size() != 0) begin
                  xfer_t e;
                  e = exp_xfer.pop_front();
                  check("xfer_is_write", fft_bus.write,   e.is_write);
                  check("xfer_address",  fft_bus.address, e.addr);
                  if (e.is_write) check("xfer_writedata", fft_bus.writedata, e.data);
               end
            end
         end else begin
            fft_bus.waitrequest = 1'b0;
            wait_left           = -1;
         end

         prev_stall = (fft_bus.read || fft_bus.write) && fft_bus.waitrequest;
         prev_addr  = fft_bus.address;
         prev_wdata = fft_bus.writedata;
         prev_rd    = fft_bus.read;
         prev_wr    = fft_bus.write;

         if (frame_done) begin
            done_cnt++;
            check("frame_done_single_cycle", prev_fd, 1'b0);
            check("busy_low_with_done",      busy,    1'b0);
            check("err_low_with_done",       err,     1'b0);
            check("peak_expected",           exp_peak.size() != 0, 1'b1);
            if (exp_peak.size() != 0) begin
               peak_t p;
               p = exp_peak.pop_front();
               check("peak_bin", peak_bin, p.bin);
               check("peak_mag", peak_mag, p.mag);
            end
         end
         prev_fd = frame_done;
      end
   end

   // ---------------------------------------------------------------- reference model
   // Expected bus traffic for one frame: the window writes, the start command,
   // `zeros` not-done polls plus one done poll, then bins 1..NBINS-1.
   task automatic prepare_frame(input int zeros, input bit done_poll);
      xfer_t x;
      peak_t p;
      int    best;
      for (int i = 0; i < FRAME_LEN; i++) begin
         x.is_write = 1'b1;
         x.addr     = DATA_BASE + 32'(4 * i);
         x.data     = 32'($signed(samples[i]));
         exp_xfer.push_back(x);
      end
      x.is_write = 1'b1; x.addr = CTRL_ADDR; x.data = 32'h1;
      exp_xfer.push_back(x);
      x.is_write = 1'b0; x.addr = STATUS_ADDR; x.data = 32'h0;
      for (int z = 0; z < zeros; z++) begin
         status_seq.push_back(1'b0);
         exp_xfer.push_back(x);
      end
      if (done_poll) begin
         status_seq.push_back(1'b1);
         exp_xfer.push_back(x);
         for (int b = 1; b < NBINS; b++) begin
            x.addr = RESULT_BASE + 32'(4 * b);
            exp_xfer.push_back(x);
         end
         best = 1;
         for (int b = 2; b < NBINS; b++)
            if (bin_val[b] > bin_val[best]) best = b;
         p.bin = 32'(best);
         p.mag = bin_val[best];
         exp_peak.push_back(p);
      end
   endtask

   // Pulse start, then stream the window; optional gaps and a stray start.
   task automatic kick_frame(input bit gaps, input int stray_start_at);
      int budget;
      bit accepted;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               s_valid = 1'b0;
               @(negedge clk);
            end
         end
         s_valid  = 1'b1;
         s_data   = samples[i];
         if (i == stray_start_at) start = 1'b1;
         accepted = 1'b0;
         budget   = 0;
         while (!accepted) begin
            #1;
            accepted = s_ready;
            @(negedge clk);
            start = 1'b0;
            budget++;
            if (budget > 200) begin
               check("sample_accepted", 1'b0, 1'b1);
               s_valid = 1'b0;
               return;
            end
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int budget = 0;
      while (done_cnt < target && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      check("frame_done_seen", done_cnt >= target, 1'b1);
      repeat (4) @(negedge clk);
      check("frame_done_count",   done_cnt,         target);
      check("xfer_queue_drained", exp_xfer.size(),  0);
      check("peak_queue_drained", exp_peak.size(),  0);
   endtask

   task automatic run_frame(input int zeros, input bit gaps);
      int target = done_cnt + 1;
      prepare_frame(zeros, 1'b1);
      kick_frame(gaps, -1);
      wait_done(target);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int          st0;
      int          budget;

      // Reset state
      #3;
      check("rst_busy",       busy,              1'b0);
      check("rst_s_ready",    s_ready,           1'b0);
      check("rst_read",       fft_bus.read,      1'b0);
      check("rst_write",      fft_bus.write,     1'b0);
      check("rst_address",    fft_bus.address,   32'h0);
      check("rst_writedata",  fft_bus.writedata, 32'h0);
      check("rst_frame_done", frame_done,        1'b0);
      check("rst_peak_bin",   peak_bin,          '0);
      check("rst_peak_mag",   peak_mag,          32'h0);
      check("rst_err",        err,               1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Frame A: samples 1..8, status 0,0,1, bins 5,9,9 -> bin 2 / 9
      for (int i = 0; i < FRAME_LEN; i++) samples[i] = 16'(i + 1);
      bin_val[0] = 32'h0; bin_val[1] = 32'd5; bin_val[2] = 32'd9; bin_val[3] = 32'd9;
      st0 = status_cnt;
      run_frame(2, 1'b0);
      check("frameA_status_reads", status_cnt - st0, 3);
      check("frameA_peak_bin_hold", peak_bin, 2);
      check("frameA_peak_mag_hold", peak_mag, 9);

      // s_valid in IDLE is not taken
      s_valid = 1'b1;
      s_data  = 16'h1234;
      repeat (3) begin
         #1;
         check("idle_s_ready", s_ready, 1'b0);
         @(negedge clk);
      end
      s_valid = 1'b0;

      // Frame B: negative full-scale sample; bin 0 huge but excluded
      for (int i = 0; i < FRAME_LEN; i++) samples[i] = 16'($urandom);
      samples[0] = 16'h8000;
      bin_val[0] = 32'hFFFF_FFFF; bin_val[1] = 32'd1; bin_val[2] = 32'd2; bin_val[3] = 32'd3;
      prepare_frame(1, 1'b1);
      kick_frame(1'b1, -1);
      check("peak_hold_during_frame", peak_mag, 9);
      wait_done(done_cnt + 1);

      // Random frames, including small values that force ties
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < FRAME_LEN; i++) samples[i] = 16'($urandom);
         for (int b = 0; b < NBINS; b++)
            bin_val[b] = (f % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         run_frame($urandom_range(0, 4), 1'b1);
      end

      // Stray start during LOAD, then reset in the middle of bin reads
      for (int i = 0; i < FRAME_LEN; i++) samples[i] = 16'($urandom);
      for (int b = 0; b < NBINS; b++) bin_val[b] = $urandom;
      st0 = done_cnt;
      prepare_frame(1, 1'b1);
      kick_frame(1'b0, 3);
      budget = 0;
      while (!(fft_bus.read && fft_bus.address >= RESULT_BASE + 4 &&
               fft_bus.address < RESULT_BASE + 4 * NBINS) && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      check("reached_bin_reads", budget < 500, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_read",       fft_bus.read,  1'b0);
      check("midrst_write",      fft_bus.write, 1'b0);
      check("midrst_busy",       busy,          1'b0);
      check("midrst_s_ready",    s_ready,       1'b0);
      check("midrst_peak_mag",   peak_mag,      32'h0);
      check("midrst_frame_done", done_cnt,      st0);
      exp_xfer.delete();
      exp_peak.delete();
      status_seq.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);

      // Recovery frame after reset
      for (int i = 0; i < FRAME_LEN; i++) samples[i] = 16'($urandom);
      for (int b = 0; b < NBINS; b++) bin_val[b] = $urandom;
      run_frame(0, 1'b1);

`ifdef FFT_SEQ_TIMEOUT_EN
      // Status stuck at 0: four polls, err, no frame_done, peak unchanged
      begin
         logic [31:0] held_mag;
         logic [31:0] held_bin;
         held_mag = peak_mag;
         held_bin = 32'(peak_bin);
         st0      = done_cnt;
         status_seq.delete();
         for (int i = 0; i < FRAME_LEN; i++) samples[i] = 16'($urandom);
         prepare_frame(4, 1'b0);
         status_seq.delete();
         kick_frame(1'b1, -1);
         budget = 0;
         while (busy && budget < 1000) begin
            @(negedge clk);
            budget++;
         end
         repeat (3) @(negedge clk);
         check("to_returned_idle",  busy,            1'b0);
         check("to_err",            err,             1'b1);
         check("to_no_frame_done",  done_cnt,        st0);
         check("to_peak_mag_held",  peak_mag,        held_mag);
         check("to_peak_bin_held",  32'(peak_bin),   held_bin);
         check("to_xfer_drained",   exp_xfer.size(), 0);
         for (int i = 0; i < FRAME_LEN; i++) samples[i] = 16'($urandom);
         for (int b = 0; b < NBINS; b++) bin_val[b] = $urandom;
         run_frame(1, 1'b0);
         check("to_err_cleared", err, 1'b0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
